noc_vchannel_mux_credit: RTL and testbench

//  Multiplexes CHANNELS virtual-channel flit streams onto one physical link.

---
 rtl/noc_vchannel_mux_credit.sv | 143 ++++++++++++++
 tb/tb_noc_vchannel_mux_credit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vchannel_mux_credit.sv
// rtl/noc_vchannel_mux_credit.sv - credit-based virtual-channel flit multiplexer with round-robin arbitration
module noc_vchannel_mux_credit #(
    parameter int FLIT_WIDTH  = 32,
    parameter int CHANNELS    = 2,
    parameter int CREDITS     = 4,
    parameter int LOCK_PACKET = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [FLIT_WIDTH-1:0]                out_flit,
    output logic                                 out_last,
    output logic [CHANNELS-1:0]                  out_valid,
    input  logic [CHANNELS-1:0]                  out_credit,
    output logic [CHANNELS-1:0]                  credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int IW = $clog2(CHANNELS);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CREDIT_MAX = cnt_t'(CREDITS);

    logic [CHANNELS-1:0][CW-1:0] credit_q, credit_d;
    logic [CHANNELS-1:0]         credit_err_q, credit_err_d;
    logic [IW-1:0]               ptr_q, ptr_d;
    logic [IW-1:0]               lock_idx_q, lock_idx_d;
    logic                        lock_vld_q, lock_vld_d;
    logic [FLIT_WIDTH-1:0]       out_flit_q, out_flit_d;
    logic                        out_last_q, out_last_d;
    logic [CHANNELS-1:0]         out_valid_q, out_valid_d;

    logic [CHANNELS-1:0]         elig;
    logic [CHANNELS-1:0]         grant_oh;
    logic                        grant_vld;
    logic [IW-1:0]               grant_idx;
    logic [IW:0]                 cand;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            elig[c] = in_valid[c] && (credit_q[c] != '0);
        end
    end

    // Descending scan so the candidate closest to ptr (smallest offset) wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if ((LOCK_PACKET != 0) && lock_vld_q) begin
            grant_vld = elig[lock_idx_q];
            grant_idx = lock_idx_q;
        end else begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                cand = {1'b0, ptr_q} + (IW+1)'(k);
                if (cand >= (IW+1)'(CHANNELS)) begin
                    cand = cand - (IW+1)'(CHANNELS);
                end
                if (elig[cand[IW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh = CHANNELS'(1) << grant_idx;
        end
    end

    assign in_ready = grant_oh;

    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        ptr_d        = ptr_q;
        lock_vld_d   = lock_vld_q;
        lock_idx_d   = lock_idx_q;
        out_flit_d   = out_flit_q;
        out_last_d   = out_last_q;
        out_valid_d  = '0;

        // A return and a send on the same edge cancel out.
        for (int c = 0; c < CHANNELS; c++) begin
            if (out_credit[c] && !grant_oh[c]) begin
                if (credit_q[c] == CREDIT_MAX) begin
                    credit_err_d[c] = 1'b1;
                end else begin
                    credit_d[c] = credit_q[c] + cnt_t'(1);
                end
            end else if (!out_credit[c] && grant_oh[c]) begin
                credit_d[c] = credit_q[c] - cnt_t'(1);
            end
        end

        if (grant_vld) begin
            out_flit_d  = in_flit[grant_idx];
            out_last_d  = in_last[grant_idx];
            out_valid_d = grant_oh;
            ptr_d       = (grant_idx == IW'(CHANNELS - 1)) ? '0 : grant_idx + IW'(1);
            if (LOCK_PACKET != 0) begin
                lock_vld_d = !in_last[grant_idx];
                lock_idx_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                credit_q[c] <= CREDIT_MAX;
            end
            credit_err_q <= '0;
            ptr_q        <= '0;
            lock_vld_q   <= 1'b0;
            lock_idx_q   <= '0;
            out_flit_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= '0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            ptr_q        <= ptr_d;
            lock_vld_q   <= lock_vld_d;
            lock_idx_q   <= lock_idx_d;
            out_flit_q   <= out_flit_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_flit   = out_flit_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_vchannel_mux_credit.sv
// tb/tb_noc_vchannel_mux_credit.sv - table-driven scoreboard bench for noc_vchannel_mux_credit
module tb_noc_vchannel_mux_credit;

    localparam int FW = 32;
    localparam int C  = 2;
    localparam int CR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [C-1:0][FW-1:0]  in_flit;
    logic [C-1:0]          in_last, in_valid, out_credit;
    logic [C-1:0]          rdy_l, ov_l, err_l, rdy_u, ov_u, err_u;
    logic [FW-1:0]         of_l, of_u;
    logic                  ol_l, ol_u;

    noc_vchannel_mux_credit #(.FLIT_WIDTH(FW), .CHANNELS(C), .CREDITS(CR), .LOCK_PACKET(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
        .in_ready(rdy_l), .out_flit(of_l), .out_last(ol_l), .out_valid(ov_l),
        .out_credit(out_credit), .credit_err(err_l));

    noc_vchannel_mux_credit #(.FLIT_WIDTH(FW), .CHANNELS(C), .CREDITS(CR), .LOCK_PACKET(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
        .in_ready(rdy_u), .out_flit(of_u), .out_last(ol_u), .out_valid(ov_u),
        .out_credit(out_credit), .credit_err(err_u));

    typedef struct {
        logic [C-1:0] v;
        logic [C-1:0] last;
        logic [C-1:0] cred;
        logic [C-1:0] rdy;
    } vec_t;

    typedef struct {
        logic [C-1:0]  oh;
        logic [FW-1:0] flit;
        logic          last;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   seq   = 0;
    bit   use_u = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] flit_of(input int s, input int c);
        return {s[15:0], c[15:0]};
    endfunction

    task automatic add(input logic [C-1:0] v, input logic [C-1:0] l,
                       input logic [C-1:0] cr, input logic [C-1:0] r);
        vec_t t;
        t.v = v; t.last = l; t.cred = cr; t.rdy = r;
        tbl.push_back(t);
    endtask

    task automatic check_out();
        exp_t          e;
        logic [C-1:0]  ov;
        logic [FW-1:0] of;
        logic          ol;
        ov = use_u ? ov_u : ov_l;
        of = use_u ? of_u : of_l;
        ol = use_u ? ol_u : ol_l;
        if (sb.size() == 0) begin
            chk("idle_out_valid", 64'(ov), 64'(0));
        end else begin
            e = sb.pop_front();
            chk("out_valid", 64'(ov), 64'(e.oh));
            if (e.oh != '0) begin
                chk("out_flit", 64'(of), 64'(e.flit));
                chk("out_last", 64'(ol), 64'(e.last));
            end
        end
    endtask

    task automatic step(input vec_t t);
        exp_t e;
        seq++;
        in_valid   = t.v;
        in_last    = t.last;
        out_credit = t.cred;
        for (int c = 0; c < C; c++) in_flit[c] = flit_of(seq, c);
        @(negedge clk);
        check_out();
        chk("in_ready", 64'(use_u ? rdy_u : rdy_l), 64'(t.rdy));
        e.oh = t.rdy; e.flit = '0; e.last = 1'b0;
        for (int c = 0; c < C; c++) begin
            if (t.rdy[c]) begin
                e.flit = flit_of(seq, c);
                e.last = t.last[c];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0; in_last = '0; out_credit = '0; in_flit = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid_l", 64'(ov_l), 64'(0));
        chk("rst_out_flit_l", 64'(of_l), 64'(0));
        chk("rst_out_last_l", 64'(ol_l), 64'(0));
        chk("rst_credit_err_l", 64'(err_l), 64'(0));
        chk("rst_out_valid_u", 64'(ov_u), 64'(0));
        chk("rst_credit_err_u", 64'(err_u), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = '0; in_last = '0; out_credit = '0; in_flit = '0;

        // 3-flit packet on VC0, then drain the last credit and stall until a return
        use_u = 1'b0;
        do_reset();
        add(2'b01, 2'b00, 2'b00, 2'b01);
        add(2'b01, 2'b00, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b00);
        add(2'b01, 2'b01, 2'b00, 2'b00);
        add(2'b01, 2'b01, 2'b01, 2'b00);
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b00, 2'b00, 2'b00, 2'b00);
        run_tbl();

        // Unlocked: alternating single flits, then multi-flit packets interleave
        use_u = 1'b1;
        do_reset();
        add(2'b11, 2'b11, 2'b00, 2'b01);
        add(2'b11, 2'b11, 2'b01, 2'b10);
        add(2'b11, 2'b11, 2'b10, 2'b01);
        add(2'b11, 2'b11, 2'b01, 2'b10);
        add(2'b11, 2'b11, 2'b10, 2'b01);
        add(2'b11, 2'b11, 2'b01, 2'b10);
        add(2'b00, 2'b00, 2'b10, 2'b00);
        add(2'b11, 2'b00, 2'b00, 2'b01);
        add(2'b11, 2'b00, 2'b00, 2'b10);
        add(2'b00, 2'b00, 2'b00, 2'b00);
        run_tbl();
        chk("unlocked_credit_err", 64'(err_u), 64'(0));

        // Packet lock holds VC0 through its gap; VC1 waits for the last flit
        use_u = 1'b0;
        do_reset();
        add(2'b11, 2'b00, 2'b00, 2'b01);
        add(2'b11, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 2'b00, 2'b00);
        add(2'b10, 2'b00, 2'b00, 2'b00);
        add(2'b10, 2'b00, 2'b00, 2'b00);
        add(2'b11, 2'b00, 2'b00, 2'b01);
        add(2'b11, 2'b01, 2'b00, 2'b01);
        add(2'b11, 2'b10, 2'b00, 2'b10);
        add(2'b00, 2'b00, 2'b00, 2'b00);
        run_tbl();

        // VC1 credit exhaustion, then simultaneous send and return keep the count
        do_reset();
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b00);
        add(2'b10, 2'b10, 2'b10, 2'b00);
        add(2'b10, 2'b10, 2'b10, 2'b10);
        add(2'b10, 2'b10, 2'b10, 2'b10);
        add(2'b10, 2'b10, 2'b10, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b00);
        add(2'b00, 2'b00, 2'b00, 2'b00);
        run_tbl();
        chk("exhaust_credit_err", 64'(err_l), 64'(0));

        // Overflowing return on VC0: sticky error, count stays at CREDITS
        do_reset();
        add(2'b00, 2'b00, 2'b01, 2'b00);
        run_tbl();
        chk("overflow_err_set", 64'(err_l), 64'(2'b01));
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b00);
        add(2'b00, 2'b00, 2'b00, 2'b00);
        run_tbl();
        chk("overflow_err_sticky", 64'(err_l), 64'(2'b01));

        // Asynchronous reset mid-packet while locked on VC1
        do_reset();
        add(2'b10, 2'b00, 2'b00, 2'b10);
        add(2'b11, 2'b00, 2'b00, 2'b10);
        run_tbl();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(ov_l), 64'(0));
        chk("async_out_flit", 64'(of_l), 64'(0));
        chk("async_out_last", 64'(ol_l), 64'(0));
        sb.delete();
        in_valid = '0; in_last = '0; out_credit = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add(2'b11, 2'b00, 2'b00, 2'b01);
        add(2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b10);
        add(2'b10, 2'b10, 2'b00, 2'b00);
        add(2'b00, 2'b00, 2'b00, 2'b00);
        run_tbl();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
